iq_slot_bank: RTL and testbench
===============================

# iq_slot_bank

Parametrised issue-queue bank holding `DEPTH` renamed micro-ops between dispatch and a single execution pipe. It generalises the single issue-queue entry to an array with physical-register tag-match wakeup over `WB_PORTS` writeback ports and oldest-first selection by ROB id. It also adds partial flush, killing only entries younger than a mispredicted branch. It sits in `backend/isu/isq`, fed by dispatch and drained by the issue/regfile-read stage.

## Interface
- `DEPTH`, 8: number of slots, ≥2.
- `WB_PORTS`, 2: writeback wakeup ports, ≥1.
- `PREG_W`, 6: physical register tag width.
- `ROBID_W`, 7: ROB id width; MSB is the wrap bit.
- `PAYLOAD_W`, 128: opaque micro-op payload (pc, imm, types, prd, sqid, …).
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `enq_valid` in 1: dispatch offers one micro-op.
- `enq_ready` out 1: a free slot exists.
- `enq_payload` in `PAYLOAD_W`: stored verbatim.
- `enq_prs1`, `enq_prs2` in `PREG_W`: source tags.
- `enq_src1_busy`, `enq_src2_busy` in 1: source not yet produced. Dispatch drives 0 for non-register sources.
- `enq_robid` in `ROBID_W`: age tag.
- `wb_valid` in `WB_PORTS`: wakeup strobes.
- `wb_prd` in `WB_PORTS*PREG_W`: wakeup tags, port i at `[i*PREG_W +: PREG_W]`.
- `iss_valid` out 1: a ready entry is selected.
- `iss_ready` in 1: pipe accepts.
- `iss_payload` out `PAYLOAD_W`; `iss_robid` out `ROBID_W`.
- `flush_valid` in 1; `flush_robid` in `ROBID_W`: kill entries strictly younger than this id.
- `count` out `$clog2(DEPTH+1)`: occupied slots (registered).

## Operation
- Per slot state: `valid`, `busy1`, `busy2`, prs1/prs2, robid, payload.
- Enqueue:
  - Fires when `enq_valid & enq_ready & ~flush_valid`.
  - The micro-op goes into the lowest-index invalid slot.
  - `enq_ready = (count != DEPTH)`, computed from registered state only. A slot freed by issue in the same cycle is not reusable until the next cycle.
- Wakeup:
  - Slot `busyN` clears when any `wb_valid[i]` is high and `wb_prd[i] == prsN`.
  - Tag 0 never wakes anything.
  - Enqueue bypass: a same-cycle tag match against `enq_prsN` stores busy = 0.
  - Wakeups to invalid slots have no effect.
- Ready: `valid & ~busy1 & ~busy2`, from registered state.
- Select:
  - Among ready slots, pick the oldest by ROB age. a is older than b iff `(a.wrap == b.wrap) ? (a.idx < b.idx) : (a.idx > b.idx)`.
  - Ties cannot occur because robids are unique.
  - `iss_valid` = any ready & `~flush_valid`.
  - `iss_payload` and `iss_robid` are AND-masked to 0 when `iss_valid` is 0.
- Issue: on `iss_valid & iss_ready` the selected slot's `valid` clears at the next edge.
- Flush: on `flush_valid`, every valid slot whose robid is younger than `flush_robid` clears. Older slots and the equal slot are kept, with wakeups still applied.
- `count` next value = count + enq_fire − iss_fire − killed. Computed as a popcount of next-state `valid`.
- Precedence: reset > flush > {issue, enqueue, wakeup}, which are mutually independent.

## Timing
- Reset: all `valid`/busy bits are 0 and `count` = 0. Outputs: `enq_ready` = 1, `iss_valid` = 0, `iss_payload` = 0, `iss_robid` = 0.
- Reset mid-operation discards all entries at that edge.
- Enqueue → earliest issue: next cycle, if both sources are non-busy or woken by the bypass.
- Wakeup → issue: 1 cycle (wakeup at edge N, `iss_valid` in cycle N+1).
- `iss_valid` may drop without `iss_ready`, due to flush. The selection may change while the pipe stalls if an older entry becomes ready.
- Full: `enq_ready` = 0 for the whole cycle, even if an issue fires that cycle.
- Empty: `iss_valid` = 0.
- Flush cycle: no enqueue, no issue. Wakeups in that cycle still apply to survivors.

## Structure
- Shared package `iq_pkg`:
  - function `rob_older(a, b)`, also used by the LSQ and ROB;
  - default widths tied to `ROB_SIZE_LOG`/`PREG_LENGTH`.
- Sub-module `iq_slot`: one slot with storage, wakeup compare over `WB_PORTS`, flush age compare, and a `ready` output.
- The bank instantiates `DEPTH` slots plus:
  - priority encoder (allocation);
  - age-matrix or tree compare (select);
  - popcount (`count`).

## Test plan
- Reset, then enqueue robid 3 with both sources non-busy → `iss_valid` = 1 next cycle with `iss_robid` = 3. With `iss_ready` = 1, `count` goes 1 → 0.
- Enqueue prs1 = 5 busy, robid 1 → no issue. Drive `wb_valid[1]` with `wb_prd` = 5 → `iss_valid` = 1 exactly one cycle later. Repeat with tag 0 → never wakes.
- Fill 8 slots with robids 0x3E, 0x3F, 0x40, 0x41… (wrap crossing), all ready, `iss_ready` held 1 → issue order 0x3E, 0x3F, 0x40, 0x41…; `enq_ready` = 0 while full.
- Robids 2, 4, 6, 8 valid; `flush_valid` with `flush_robid` = 4 → 2 and 4 survive, `count` = 2. Same-cycle `enq_valid` is dropped and `iss_valid` = 0.
- Full bank with issue and enqueue in the same cycle → enqueue is refused, `count` = 7. Enqueue bypass: `enq_prs2` = 9 with `wb_prd` = 9 in the same cycle → issues next cycle.

Source files
------------

// File: rtl/iq_pkg.sv
// iq_pkg: shared issue-queue default widths and ROB age compare
package iq_pkg;
    localparam int ROB_SIZE_LOG = 6;
    localparam int PREG_LENGTH  = 6;
    localparam int IQ_ROBID_W   = ROB_SIZE_LOG + 1;
    localparam int IQ_PREG_W    = PREG_LENGTH;
    localparam int IQ_PAYLOAD_W = 128;

    function automatic logic rob_older(input logic a_wrap, input logic [31:0] a_idx,
                                       input logic b_wrap, input logic [31:0] b_idx);
        return (a_wrap == b_wrap) ? (a_idx < b_idx) : (a_idx > b_idx);
    endfunction
endpackage

// File: rtl/iq_slot.sv
// iq_slot: one issue-queue entry with tag wakeup and age-based flush
module iq_slot
    import iq_pkg::*;
#(
    parameter int WB_PORTS  = 2,
    parameter int PREG_W    = IQ_PREG_W,
    parameter int ROBID_W   = IQ_ROBID_W,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alloc,
    input  logic                       issue,
    input  logic [PAYLOAD_W-1:0]       enq_payload,
    input  logic [PREG_W-1:0]          enq_prs1,
    input  logic [PREG_W-1:0]          enq_prs2,
    input  logic                       enq_src1_busy,
    input  logic                       enq_src2_busy,
    input  logic [ROBID_W-1:0]         enq_robid,
    input  logic [WB_PORTS-1:0]        wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0] wb_prd,
    input  logic                       flush_valid,
    input  logic [ROBID_W-1:0]         flush_robid,
    output logic                       valid,
    output logic                       valid_nxt,
    output logic                       ready,
    output logic [ROBID_W-1:0]         robid,
    output logic [PAYLOAD_W-1:0]       payload
);
    logic              busy1, busy2;
    logic [PREG_W-1:0] prs1, prs2;
    logic              wake1, wake2, enq_wake1, enq_wake2, kill;

    // tag match of stored and incoming sources against every writeback port; tag 0 never matches
    always_comb begin
        wake1     = 1'b0;
        wake2     = 1'b0;
        enq_wake1 = 1'b0;
        enq_wake2 = 1'b0;
        for (int i = 0; i < WB_PORTS; i++) begin
            wake1     |= wb_valid[i] && prs1 != '0 && wb_prd[i*PREG_W +: PREG_W] == prs1;
            wake2     |= wb_valid[i] && prs2 != '0 && wb_prd[i*PREG_W +: PREG_W] == prs2;
            enq_wake1 |= wb_valid[i] && enq_prs1 != '0 && wb_prd[i*PREG_W +: PREG_W] == enq_prs1;
            enq_wake2 |= wb_valid[i] && enq_prs2 != '0 && wb_prd[i*PREG_W +: PREG_W] == enq_prs2;
        end
    end

    assign kill      = flush_valid && valid &&
                       rob_older(flush_robid[ROBID_W-1], 32'(flush_robid[ROBID_W-2:0]),
                                 robid[ROBID_W-1], 32'(robid[ROBID_W-2:0]));
    assign valid_nxt = alloc || (valid && !kill && !issue);
    assign ready     = valid && !busy1 && !busy2;

    // occupancy and busy bits: allocation loads with bypass, otherwise wakeups clear
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            busy1 <= 1'b0;
            busy2 <= 1'b0;
        end else begin
            valid <= valid_nxt;
            busy1 <= alloc ? (enq_src1_busy && !enq_wake1) : (busy1 && !wake1);
            busy2 <= alloc ? (enq_src2_busy && !enq_wake2) : (busy2 && !wake2);
        end
    end

    // datapath fields only change on allocation and are qualified by valid
    always_ff @(posedge clock) begin
        if (alloc) begin
            prs1    <= enq_prs1;
            prs2    <= enq_prs2;
            robid   <= enq_robid;
            payload <= enq_payload;
        end
    end
endmodule

// File: rtl/iq_slot_bank.sv
// iq_slot_bank: DEPTH-entry issue queue bank with wakeup, oldest-first select and partial flush
module iq_slot_bank
    import iq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int WB_PORTS  = 2,
    parameter int PREG_W    = IQ_PREG_W,
    parameter int ROBID_W   = IQ_ROBID_W,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [PAYLOAD_W-1:0]         enq_payload,
    input  logic [PREG_W-1:0]            enq_prs1,
    input  logic [PREG_W-1:0]            enq_prs2,
    input  logic                         enq_src1_busy,
    input  logic                         enq_src2_busy,
    input  logic [ROBID_W-1:0]           enq_robid,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*PREG_W-1:0]   wb_prd,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [PAYLOAD_W-1:0]         iss_payload,
    output logic [ROBID_W-1:0]           iss_robid,
    input  logic                         flush_valid,
    input  logic [ROBID_W-1:0]           flush_robid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     valid, valid_nxt, ready, alloc, sel, issue;
    logic [ROBID_W-1:0]   robid [DEPTH];
    logic [PAYLOAD_W-1:0] payload [DEPTH];
    logic [ROBID_W-1:0]   sel_robid;
    logic [PAYLOAD_W-1:0] sel_payload;
    logic [CNT_W-1:0]     count_nxt;
    logic                 enq_fire;

    function automatic logic older(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] b);
        return rob_older(a[ROBID_W-1], 32'(a[ROBID_W-2:0]), b[ROBID_W-1], 32'(b[ROBID_W-2:0]));
    endfunction

    assign enq_ready   = count != CNT_W'(DEPTH);
    assign enq_fire    = enq_valid && enq_ready && !flush_valid;
    assign iss_valid   = |ready && !flush_valid;
    assign iss_robid   = iss_valid ? sel_robid : '0;
    assign iss_payload = iss_valid ? sel_payload : '0;
    assign issue       = sel & {DEPTH{iss_valid && iss_ready}};

    // allocation: lowest-index free slot wins
    always_comb begin
        alloc = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (enq_fire && !valid[i]) begin
                alloc    = '0;
                alloc[i] = 1'b1;
            end
        end
    end

    // age matrix: a ready slot is selected unless some other ready slot is older
    always_comb begin
        sel         = ready;
        sel_robid   = '0;
        sel_payload = '0;
        for (int i = 0; i < DEPTH; i++)
            for (int j = 0; j < DEPTH; j++)
                if (j != i && ready[j] && older(robid[j], robid[i])) sel[i] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            sel_robid   |= sel[i] ? robid[i] : '0;
            sel_payload |= sel[i] ? payload[i] : '0;
        end
    end

    // popcount of next-state occupancy
    always_comb begin
        count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) count_nxt += CNT_W'(valid_nxt[i]);
    end

    // registered occupancy count
    always_ff @(posedge clock) begin
        count <= reset ? '0 : count_nxt;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        iq_slot #(
            .WB_PORTS (WB_PORTS),
            .PREG_W   (PREG_W),
            .ROBID_W  (ROBID_W),
            .PAYLOAD_W(PAYLOAD_W)
        ) u_slot (
            .clock        (clock),
            .reset        (reset),
            .alloc        (alloc[g]),
            .issue        (issue[g]),
            .enq_payload  (enq_payload),
            .enq_prs1     (enq_prs1),
            .enq_prs2     (enq_prs2),
            .enq_src1_busy(enq_src1_busy),
            .enq_src2_busy(enq_src2_busy),
            .enq_robid    (enq_robid),
            .wb_valid     (wb_valid),
            .wb_prd       (wb_prd),
            .flush_valid  (flush_valid),
            .flush_robid  (flush_robid),
            .valid        (valid[g]),
            .valid_nxt    (valid_nxt[g]),
            .ready        (ready[g]),
            .robid        (robid[g]),
            .payload      (payload[g])
        );
    end
endmodule

// File: tb/tb_iq_slot_bank.sv
// tb_iq_slot_bank: directed vector table, wrap-crossing sequence and randomized model check
module tb_iq_slot_bank;
    logic         clock, reset;
    logic         enq_valid, enq_ready, enq_src1_busy, enq_src2_busy;
    logic [127:0] enq_payload, iss_payload;
    logic [5:0]   enq_prs1, enq_prs2;
    logic [6:0]   enq_robid, iss_robid, flush_robid;
    logic [1:0]   wb_valid;
    logic [11:0]  wb_prd;
    logic         iss_valid, iss_ready, flush_valid;
    logic [3:0]   count;

    int n_vec = 0;
    int n_bad = 0;

    iq_slot_bank dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_payload(enq_payload),
        .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
        .enq_src1_busy(enq_src1_busy), .enq_src2_busy(enq_src2_busy), .enq_robid(enq_robid),
        .wb_valid(wb_valid), .wb_prd(wb_prd),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload), .iss_robid(iss_robid),
        .flush_valid(flush_valid), .flush_robid(flush_robid), .count(count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic rst, ev; logic [5:0] p1, p2; logic b1, b2; logic [6:0] rob;
        logic [1:0] wv; logic [5:0] w0, w1; logic ir, fv; logic [6:0] frob;
        logic er, iv; logic [6:0] irob; logic [3:0] cnt;
    } vec_t;

    typedef struct {
        logic [6:0] rob; logic [5:0] p1, p2; logic b1, b2; logic [127:0] pay;
    } ent_t;

    ent_t       q[$];
    logic [6:0] next_rob = 7'h30;

    function automatic vec_t row(input logic rst, ev, input logic [5:0] p1, p2, input logic b1, b2,
                                 input logic [6:0] rob, input logic [1:0] wv, input logic [5:0] w0, w1,
                                 input logic ir, fv, input logic [6:0] frob, input logic er, iv,
                                 input logic [6:0] irob, input logic [3:0] cnt);
        return '{rst, ev, p1, p2, b1, b2, rob, wv, w0, w1, ir, fv, frob, er, iv, irob, cnt};
    endfunction

    function automatic logic [127:0] pay(input logic [6:0] r);
        return {16{r, 1'b1}};
    endfunction

    // a older than b when b lies 1..63 steps ahead of a on the 128-entry ROB ring
    function automatic logic older_m(input logic [6:0] a, input logic [6:0] b);
        logic [6:0] d;
        d = 7'(b - a);
        return d >= 7'd1 && d <= 7'd63;
    endfunction

    function automatic logic woke(input logic [5:0] p, input logic [1:0] wv, input logic [5:0] w0, w1);
        return p != 6'd0 && ((wv[0] && w0 == p) || (wv[1] && w1 == p));
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic rst, ev, input logic [5:0] p1, p2, input logic b1, b2,
                         input logic [6:0] rob, input logic [127:0] pl, input logic [1:0] wv,
                         input logic [5:0] w0, w1, input logic ir, fv, input logic [6:0] frob);
        @(negedge clock);
        reset = rst; enq_valid = ev; enq_prs1 = p1; enq_prs2 = p2;
        enq_src1_busy = b1; enq_src2_busy = b2; enq_robid = rob; enq_payload = pl;
        wb_valid = wv; wb_prd = {w1, w0}; iss_ready = ir; flush_valid = fv; flush_robid = frob;
        #1;
    endtask

    task automatic step(input vec_t v);
        drive(v.rst, v.ev, v.p1, v.p2, v.b1, v.b2, v.rob, pay(v.rob), v.wv, v.w0, v.w1, v.ir, v.fv, v.frob);
        chk("enq_ready", 128'(enq_ready), 128'(v.er));
        chk("iss_valid", 128'(iss_valid), 128'(v.iv));
        chk("iss_robid", 128'(iss_robid), 128'(v.irob));
        chk("iss_payload", iss_payload, v.iv ? pay(v.irob) : 128'd0);
        chk("count", 128'(count), 128'(v.cnt));
    endtask

    task automatic rand_cycle();
        logic ev, ir, fv, b1, b2, iv, fire;
        logic [5:0] p1, p2, w0, w1;
        logic [1:0] wv;
        logic [6:0] frob, irob, span;
        logic [127:0] pl, ipay;
        ent_t keep[$];
        int sel;
        ev = $urandom_range(0, 3) != 0;
        span = 7'd0;
        foreach (q[i]) if (7'(next_rob - q[i].rob) > span) span = 7'(next_rob - q[i].rob);
        if (span >= 7'd48) ev = 1'b0;
        p1 = 6'($urandom_range(0, 7));
        p2 = 6'($urandom_range(0, 7));
        b1 = p1 != 6'd0 && $urandom_range(0, 1) == 1;
        b2 = p2 != 6'd0 && $urandom_range(0, 1) == 1;
        wv = 2'($urandom_range(0, 3));
        w0 = 6'($urandom_range(0, 7));
        w1 = 6'($urandom_range(0, 7));
        ir = $urandom_range(0, 3) != 0;
        fv = $urandom_range(0, 19) == 0;
        frob = q.size() != 0 ? q[$urandom_range(0, q.size() - 1)].rob : 7'(next_rob - 1);
        pl = {$urandom, $urandom, $urandom, $urandom};
        sel = -1;
        foreach (q[i])
            if (!q[i].b1 && !q[i].b2 && (sel < 0 || older_m(q[i].rob, q[sel].rob))) sel = i;
        iv = sel >= 0 && !fv;
        irob = iv ? q[sel].rob : 7'd0;
        ipay = iv ? q[sel].pay : 128'd0;
        drive(1'b0, ev, p1, p2, b1, b2, next_rob, pl, wv, w0, w1, ir, fv, frob);
        chk("rnd_enq_ready", 128'(enq_ready), 128'(q.size() != 8));
        chk("rnd_iss_valid", 128'(iss_valid), 128'(iv));
        chk("rnd_iss_robid", 128'(iss_robid), 128'(irob));
        chk("rnd_iss_payload", iss_payload, ipay);
        chk("rnd_count", 128'(count), 128'(q.size()));
        fire = ev && q.size() < 8 && !fv;
        if (fv) begin
            foreach (q[i]) if (!older_m(frob, q[i].rob)) keep.push_back(q[i]);
            q = keep;
            next_rob = 7'(frob + 1);
        end else if (iv && ir) q.delete(sel);
        foreach (q[i]) begin
            if (woke(q[i].p1, wv, w0, w1)) q[i].b1 = 1'b0;
            if (woke(q[i].p2, wv, w0, w1)) q[i].b2 = 1'b0;
        end
        if (fire) begin
            q.push_back('{next_rob, p1, p2, b1 && !woke(p1, wv, w0, w1), b2 && !woke(p2, wv, w0, w1), pl});
            next_rob = 7'(next_rob + 1);
        end
    endtask

    initial begin
        vec_t tbl[$];
        logic [6:0] ord [8];
        logic [6:0] old [8];
        reset = 1'b1; enq_valid = 1'b0; enq_prs1 = '0; enq_prs2 = '0; enq_src1_busy = 1'b0;
        enq_src2_busy = 1'b0; enq_robid = '0; enq_payload = '0; wb_valid = '0; wb_prd = '0;
        iss_ready = 1'b0; flush_valid = 1'b0; flush_robid = '0;
        repeat (2) @(posedge clock);

        tbl.push_back(row(0, 1, 1, 2, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 3, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 1, 5, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 2, 0, 5, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
        tbl.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 1, 1, 2, 1));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 10, 0, 0, 0, 1, 1, 4, 1, 0, 0, 4));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 2));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 2, 2));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 4, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(row(0, 1, 0, 0, 0, 0, 7'(16 + k), 0, 0, 0, 0, 0, 0, 1, k != 0, k != 0 ? 7'h10 : 7'h0, 4'(k)));
        tbl.push_back(row(0, 1, 0, 0, 0, 0, 7'h18, 0, 0, 0, 1, 0, 0, 0, 1, 7'h10, 8));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7'h11, 7));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7'h11, 1, 0, 0, 7));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 7'h11, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 1, 0, 9, 0, 1, 7'h20, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 7'h20, 1));
        tbl.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        foreach (tbl[i]) step(tbl[i]);

        ord = '{7'h41, 7'h3F, 7'h44, 7'h3E, 7'h43, 7'h40, 7'h45, 7'h42};
        old = '{7'h00, 7'h41, 7'h3F, 7'h3F, 7'h3E, 7'h3E, 7'h3E, 7'h3E};
        for (int k = 0; k < 8; k++)
            step(row(0, 1, 0, 0, 0, 0, ord[k], 0, 0, 0, 0, 0, 0, 1, k != 0, old[k], 4'(k)));
        step(row(0, 1, 0, 0, 0, 0, 7'h46, 0, 0, 0, 1, 0, 0, 0, 1, 7'h3E, 8));
        for (int k = 1; k < 8; k++)
            step(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 7'(7'h3E + k), 4'(8 - k)));
        step(row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

        repeat (3000) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
